// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: takes a length-prefixed, XOR-checksummed byte
// stream, packs little-endian 32-bit words, writes them from address 0 upward
// and holds the CPU in reset until a verified image is in place.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Byte_valid,
  input  logic [7:0]        Byte_data,
  output logic              Byte_ready,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [31:0]       Mem_wdata,
  output logic              Cpu_rst,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Words_loaded
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             start_load;
  logic             busy_nxt;
  logic             last_word;
  logic [15:0]      len_full;
  logic [7:0]       len_lo;
  logic [CNT_W-1:0] n_words;
  logic [7:0]       xor_acc;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;

  assign accept    = Byte_ready & Byte_valid;
  assign len_full  = {Byte_data, len_lo};
  assign last_word = (Words_loaded + CNT_W'(1)) == n_words;
  assign busy_nxt  = (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                     (state_nxt == S_DATA) || (state_nxt == S_CSUM);

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; a load only (re)starts from a quiescent state
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_nxt  = S_LEN0;
          start_load = 1'b1;
        end
      end
      S_LEN0: if (accept) state_nxt = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (len_full == 16'd0)                 state_nxt = S_CSUM;
          else if (32'(len_full) > MAX_WORDS)    state_nxt = S_ERROR;
          else                                   state_nxt = S_DATA;
        end
      end
      S_DATA: if (accept && byte_idx == 2'd3 && last_word) state_nxt = S_CSUM;
      S_CSUM: begin
        if (accept) state_nxt = (Byte_data == xor_acc) ? S_DONE : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Byte_ready <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      Cpu_rst    <= 1'b1;
    end else begin
      Byte_ready <= busy_nxt;
      Busy       <= busy_nxt;
      Done       <= (state_nxt == S_DONE);
      Error      <= (state_nxt == S_ERROR);
      Cpu_rst    <= (state_nxt != S_DONE);
    end
  end

  // Byte datapath: length capture, checksum, word assembly and memory write
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Mem_we       <= 1'b0;
      Mem_addr     <= '0;
      Mem_wdata    <= '0;
      Words_loaded <= '0;
      len_lo       <= '0;
      n_words      <= '0;
      xor_acc      <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
    end else begin
      Mem_we <= 1'b0;
      if (start_load) begin
        xor_acc      <= '0;
        byte_idx     <= '0;
        Words_loaded <= '0;
      end else if (accept) begin
        xor_acc <= xor_acc ^ Byte_data;
        case (state)
          S_LEN0: len_lo  <= Byte_data;
          S_LEN1: n_words <= CNT_W'(len_full);
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= Byte_data;
              2'd1: word_buf[15:8]  <= Byte_data;
              2'd2: word_buf[23:16] <= Byte_data;
              default: begin
                Mem_we       <= 1'b1;
                Mem_addr     <= Words_loaded[ADDR_W-1:0];
                Mem_wdata    <= {Byte_data, word_buf};
                Words_loaded <= Words_loaded + CNT_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Instruction-memory boot loader that is the writing end of the CPU's instruction-memory interface. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory from word address 0. It holds the CPU in reset until a complete, verified image has been loaded.

## Interface

Parameters:
- ADDR_W, 8, instruction-memory word-address width; maximum image size is 2^ADDR_W words.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- Byte_valid  input  1  Byte_data holds a valid byte.
- Byte_data  input  8  stream byte.
- Byte_ready  output  1  loader can accept a byte this cycle.
- Mem_we  output  1  instruction-memory write strobe, one cycle per word.
- Mem_addr  output  ADDR_W  word address for the write.
- Mem_wdata  output  32  word to write.
- Cpu_rst  output  1  active-high reset driven to the CPU's Rst input.
- Busy  output  1  a load is in progress.
- Done  output  1  the last load completed with a good checksum.
- Error  output  1  the last load failed.
- Words_loaded  output  ADDR_W+1  number of words written by the current or last load.

## Operation

- **Byte acceptance:** a byte is accepted on a rising edge where Byte_valid=1 and Byte_ready=1.
- **Byte_ready:** equals 1 exactly in states LEN0, LEN1, DATA and CSUM. There are no internal stalls.
- **Stream format:**
  - LEN_L, LEN_H: 16-bit word count N, little-endian.
  - 4·N data bytes: each word is sent least-significant byte first.
  - CSUM: XOR of every preceding byte, including the length bytes.
- **State transitions:**
  - IDLE → LEN0 on Start.
  - LEN0 → LEN1 on accept.
  - LEN1 → DATA on accept when 1 ≤ N ≤ 2^ADDR_W.
  - LEN1 → CSUM on accept when N = 0.
  - LEN1 → ERROR on accept when N > 2^ADDR_W. No data bytes are consumed in this case.
  - DATA → CSUM on acceptance of byte 4·N.
  - CSUM → DONE on accept when the byte equals the running XOR.
  - CSUM → ERROR on accept when the byte does not equal the running XOR.
  - DONE or ERROR → LEN0 on Start.
- **Start handling:** on entering LEN0, the running XOR, byte counter and Words_loaded are cleared, and Done and Error are cleared. Start in LEN0, LEN1, DATA or CSUM is ignored.
- **Word writes:**
  - After the 4th byte of word k is accepted, on the next cycle: Mem_we=1, Mem_addr=k, Mem_wdata = {b3,b2,b1,b0}.
  - Words_loaded increments in that same cycle.
  - Mem_addr and Mem_wdata hold their values when Mem_we=0.
  - Words already written are not undone by a later checksum error.
- **Status outputs:**
  - Cpu_rst = 0 only in DONE; it is 1 in every other state.
  - Busy = 1 in LEN0, LEN1, DATA and CSUM.
  - Done = 1 in DONE; Error = 1 in ERROR.
- **Widths:** the running XOR is 8 bits. The byte-within-word index is 2 bits and wraps 3→0. The word address is ADDR_W bits; it never wraps, because N is bounded by the LEN1 check.

## Timing

- **Reset values:** while Rst=0, asynchronously and independent of Clk:
  - state = IDLE; Byte_ready = 0.
  - Mem_we = 0, Mem_addr = 0, Mem_wdata = 0.
  - Cpu_rst = 1; Busy = 0, Done = 0, Error = 0.
  - Words_loaded = 0.
- **Reset mid-load:** behaves identically to reset from any other state. Partial memory contents remain, and the CPU stays in reset until a new Start completes a load.
- **Start latency:** Start sampled high → Busy=1 and Byte_ready=1 from the next cycle.
- **Write latency:** Mem_we is asserted exactly 1 cycle after the 4th byte of a word is accepted. With back-to-back bytes, writes occur every 4 cycles.
- **Final byte to checksum:** the write for the last word and acceptance of CSUM may occur in the same cycle. Both must take effect.
- **Completion latency:** the cycle after CSUM is accepted:
  - Cpu_rst = 0 and Done = 1 when the checksum is good.
  - Error = 1 and Cpu_rst = 1 when it is bad.
- **Leaving DONE:** Start in DONE raises Cpu_rst to 1 on the next cycle.
- **Output timing:** all outputs are registered or decoded from state only. No combinational path from Byte_valid to Byte_ready.

## Test plan

- **Good 2-word load:** Start, then back-to-back bytes 02 00 13 00 00 00 93 00 10 00 92.
  - Write 0x00000013 at address 0; write 0x00100093 at address 1, 4 cycles later.
  - Done=1, Cpu_rst=0 one cycle after byte 0x92; Words_loaded=2.
- **Bad checksum:** same stream with a final byte of 0x93.
  - Both writes still occur.
  - Error=1, Done=0, Cpu_rst stays 1.
  - A following Start plus a good stream reaches DONE.
- **Empty image:** bytes 00 00 00.
  - No Mem_we; Done=1, Cpu_rst=0, Words_loaded=0.
- **Oversize length (ADDR_W=8):** bytes 01 01.
  - Error=1 one cycle after the second byte; Byte_ready=0.
  - No Mem_we; Cpu_rst=1.
- **Sparse valid:** Byte_valid toggles every other cycle.
  - Identical writes and result to the good 2-word load.
  - A Start pulse mid-DATA is ignored: no restart, and Words_loaded continues counting.
- **Async reset mid-load:** Rst=0 between edges after the 5th byte.
  - All outputs take their reset values immediately, before the next edge.
  - After Rst=1, no activity until Start.
